// File: rtl/systolic_pkg.sv
// Shared types and width helpers for the N x N systolic stream multiplier.
package systolic_pkg;

  typedef enum logic [1:0] {StIdle, StLoad, StFlush, StOut} state_e;

  // Accumulator width: full product plus headroom for kmax additions.
  function automatic int unsigned calc_acc_w(int unsigned width, int unsigned kmax);
    return 2 * width + $clog2(kmax);
  endfunction

  function automatic int unsigned calc_kw(int unsigned kmax);
    return $clog2(kmax + 1);
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// One processing element: MAC on the aligned (a, b) pair, forwards A right and B down.
// Define SYSTOLIC_SIGNED_EN for two's-complement operands; otherwise operands are unsigned.
module systolic_pe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ACC_W = 36
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [ACC_W-1:0] acc
);

  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic [ACC_W-1:0]   prod_ext;

`ifdef SYSTOLIC_SIGNED_EN
  assign a_ext    = {{WIDTH{a_in[WIDTH-1]}}, a_in};
  assign b_ext    = {{WIDTH{b_in[WIDTH-1]}}, b_in};
  assign prod     = a_ext * b_ext;
  assign prod_ext = {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
`else
  assign a_ext    = {{WIDTH{1'b0}}, a_in};
  assign b_ext    = {{WIDTH{1'b0}}, b_in};
  assign prod     = a_ext * b_ext;
  assign prod_ext = {{(ACC_W-2*WIDTH){1'b0}}, prod};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= clr ? '0 : acc + prod_ext;
    end
  end

endmodule

// File: rtl/systolic_nxn_stream_mult.sv
// Streaming N x N output-stationary systolic matrix multiplier with skewed edge feeds.
// SYSTOLIC_SIGNED_EN (in systolic_pe) selects signed arithmetic.
module systolic_nxn_stream_mult
  import systolic_pkg::*;
#(
  parameter  int unsigned WIDTH = 16,
  parameter  int unsigned N     = 4,
  parameter  int unsigned KMAX  = 16,
  localparam int unsigned ACC_W = calc_acc_w(WIDTH, KMAX),
  localparam int unsigned KW    = calc_kw(KMAX)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [KW-1:0]        k_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH*N-1:0]   a_col,
  input  logic [WIDTH*N-1:0]   b_row,
  output logic [ACC_W*N*N-1:0] c_flat,
  output logic                 c_valid,
  input  logic                 c_ready,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned CW = $clog2(KMAX + 2 * N + 1);

  state_e        state;
  logic [KW-1:0] k_q, k_sat;
  logic [CW-1:0] cnt;
  logic          accept, clr;

  assign accept = in_valid && in_ready;
  assign clr    = (state == StIdle) && start;
  assign k_sat  = (k_len > KW'(KMAX)) ? KW'(KMAX) : k_len;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= StIdle;
      k_q      <= '0;
      cnt      <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      c_valid  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
            k_q  <= k_sat;
            if (k_sat == '0) begin
              state   <= StOut;
              c_valid <= 1'b1;
            end else begin
              state    <= StLoad;
              in_ready <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (accept) begin
            if (cnt == CW'(k_q) - CW'(1)) begin
              state    <= StFlush;
              in_ready <= 1'b0;
              cnt      <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        StFlush: begin
          // Last pair reaches PE(N-1,N-1) 2N-1 edges after acceptance.
          if (cnt == CW'(2 * N - 1)) begin
            state   <= StOut;
            c_valid <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        StOut: begin
          if (c_ready) begin
            state   <= StIdle;
            c_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  logic [WIDTH-1:0] a_edge [N];
  logic [WIDTH-1:0] b_edge [N];
  logic [WIDTH-1:0] a_link [N][N];
  logic [WIDTH-1:0] b_link [N][N];

  // Row/column g sees its operand g cycles late; bubbles shift in zeros.
  for (genvar g = 0; g < N; g++) begin : g_skew
    logic [WIDTH-1:0] a_sr [g+1];
    logic [WIDTH-1:0] b_sr [g+1];
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int s = 0; s <= g; s++) begin
          a_sr[s] <= '0;
          b_sr[s] <= '0;
        end
      end else begin
        a_sr[0] <= accept ? a_col[WIDTH*g +: WIDTH] : '0;
        b_sr[0] <= accept ? b_row[WIDTH*g +: WIDTH] : '0;
        for (int s = 1; s <= g; s++) begin
          a_sr[s] <= a_sr[s-1];
          b_sr[s] <= b_sr[s-1];
        end
      end
    end
    assign a_edge[g] = a_sr[g];
    assign b_edge[g] = b_sr[g];
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic [WIDTH-1:0] pe_a, pe_b;
      if (gj == 0) begin : g_a_edge
        assign pe_a = a_edge[gi];
      end else begin : g_a_link
        assign pe_a = a_link[gi][gj-1];
      end
      if (gi == 0) begin : g_b_edge
        assign pe_b = b_edge[gj];
      end else begin : g_b_link
        assign pe_b = b_link[gi-1][gj];
      end
      systolic_pe #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W)
      ) u_pe (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .a_in  (pe_a),
        .b_in  (pe_b),
        .a_out (a_link[gi][gj]),
        .b_out (b_link[gi][gj]),
        .acc   (c_flat[ACC_W*(N*gi+gj) +: ACC_W])
      );
    end
  end

endmodule

// File: tb/tb_systolic_nxn_stream_mult.sv
// Self-checking bench for systolic_nxn_stream_mult against a sum-of-products matrix model.
module tb_systolic_nxn_stream_mult;

  localparam int W   = 16;
  localparam int NN  = 4;
  localparam int KM  = 16;
  localparam int AW  = 36;
  localparam int KWB = 5;

  logic               clk      = 1'b0;
  logic               rst_n    = 1'b0;
  logic               start    = 1'b0;
  logic [KWB-1:0]     k_len    = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [W*NN-1:0]    a_col    = '0;
  logic [W*NN-1:0]    b_row    = '0;
  logic [AW*NN*NN-1:0] c_flat;
  logic               c_valid;
  logic               c_ready  = 1'b0;
  logic               busy;
  logic               done;

  int total  = 0;
  int passed = 0;

  // a_m[k][i] = A[i][k], b_m[k][j] = B[k][j]
  logic [W-1:0]  a_m [KM][NN];
  logic [W-1:0]  b_m [KM][NN];
  logic [AW-1:0] exp_c [NN][NN];

  always #5 clk = ~clk;

  systolic_nxn_stream_mult #(
    .WIDTH (W),
    .N     (NN),
    .KMAX  (KM)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .k_len    (k_len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_col    (a_col),
    .b_row    (b_row),
    .c_flat   (c_flat),
    .c_valid  (c_valid),
    .c_ready  (c_ready),
    .busy     (busy),
    .done     (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  function automatic longint ext(input logic [W-1:0] x);
`ifdef SYSTOLIC_SIGNED_EN
    return longint'($signed(x));
`else
    return longint'(x);
`endif
  endfunction

  task automatic compute_model(input int keff);
    for (int i = 0; i < NN; i++) begin
      for (int j = 0; j < NN; j++) begin
        longint s = 0;
        for (int k = 0; k < keff; k++) s += ext(a_m[k][i]) * ext(b_m[k][j]);
        exp_c[i][j] = s[AW-1:0];
      end
    end
  endtask

  function automatic bit results_ok();
    bit ok = 1'b1;
    for (int i = 0; i < NN; i++)
      for (int j = 0; j < NN; j++)
        if (c_flat[AW*(NN*i+j) +: AW] !== exp_c[i][j]) ok = 1'b0;
    return ok;
  endfunction

  task automatic feed(input bit toggle, output int acc);
    int cyc = 0;
    bit ph  = 1'b0;
    acc = 0;
    while (in_ready && cyc < 100) begin
      in_valid = toggle ? ph : 1'b1;
      ph = ~ph;
      for (int i = 0; i < NN; i++) begin
        a_col[W*i +: W] = in_valid ? a_m[acc % KM][i] : W'($urandom);
        b_row[W*i +: W] = in_valid ? b_m[acc % KM][i] : W'($urandom);
      end
      @(posedge clk);
      if (in_valid) acc++;
      #1;
      cyc++;
    end
    in_valid = 1'b0;
  endtask

  task automatic full_run(input string tag, input int klen, input bit toggle, input int stall);
    int keff, acc, edges;
    keff = (klen > KM) ? KM : klen;
    compute_model(keff);
    k_len = KWB'(klen);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " busy"}, 64'(busy), 64'd1);
    check({tag, " in_ready"}, 64'(in_ready), 64'(keff != 0));
    feed(toggle, acc);
    check({tag, " pairs"}, 64'(acc), 64'(keff));
    check({tag, " in_ready low"}, 64'(in_ready), 64'd0);
    edges = 0;
    while (!c_valid && edges < 64) begin
      tick();
      edges++;
    end
    check({tag, " latency"}, 64'(edges), 64'((keff != 0) ? 2 * NN : 0));
    for (int i = 0; i < NN; i++)
      for (int j = 0; j < NN; j++)
        check($sformatf("%s C[%0d][%0d]", tag, i, j),
              64'(c_flat[AW*(NN*i+j) +: AW]), 64'(exp_c[i][j]));
    for (int s = 0; s < stall; s++) begin
      start = (s == 2);
      k_len = KWB'(3);
      tick();
      check($sformatf("%s stall%0d c_valid", tag, s), 64'(c_valid), 64'd1);
      check($sformatf("%s stall%0d done", tag, s), 64'(done), 64'd0);
      check($sformatf("%s stall%0d stable", tag, s), 64'(results_ok()), 64'd1);
    end
    start   = 1'b0;
    c_ready = 1'b1;
    tick();
    c_ready = 1'b0;
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " c_valid drop"}, 64'(c_valid), 64'd0);
    check({tag, " idle busy"}, 64'(busy), 64'd0);
    tick();
    check({tag, " done pulse"}, 64'(done), 64'd0);
    check({tag, " retain"}, 64'(results_ok()), 64'd1);
  endtask

  task automatic load_ramp_identity();
    for (int k = 0; k < KM; k++)
      for (int i = 0; i < NN; i++) begin
        a_m[k][i] = W'(i + k);
        b_m[k][i] = (k == i) ? W'(1) : W'(0);
      end
  endtask

  task automatic load_random();
    for (int k = 0; k < KM; k++)
      for (int i = 0; i < NN; i++) begin
        a_m[k][i] = W'($urandom);
        b_m[k][i] = W'($urandom);
      end
  endtask

  initial begin
    bit bad;
    logic [AW-1:0] sat_exp;

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    check("rst in_ready", 64'(in_ready), 64'd0);
    check("rst c_valid", 64'(c_valid), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst c_flat", 64'(|c_flat), 64'd0);
    rst_n = 1'b1;
    tick();

    // A[i][j]=i+j with identity B, streaming then with bubbles
    load_ramp_identity();
    full_run("ident", 4, 1'b0, 0);
    full_run("bubble", 4, 1'b1, 0);
    full_run("stall", 4, 1'b0, 5);

    // All-ones A times 2, full inner dimension
    for (int k = 0; k < KM; k++)
      for (int i = 0; i < NN; i++) begin
        a_m[k][i] = 16'hFFFF;
        b_m[k][i] = 16'd2;
      end
    full_run("sat", 16, 1'b0, 0);
`ifdef SYSTOLIC_SIGNED_EN
    sat_exp = 36'hFFFFFFFE0;
`else
    sat_exp = 36'd2097120;
`endif
    check("sat const", 64'(c_flat[AW-1:0]), 64'(sat_exp));

    // Random runs
    for (int r = 0; r < 3; r++) begin
      load_random();
      full_run($sformatf("rand%0d", r), $urandom_range(1, KM), 1'($urandom), 0);
    end

    // Reset in the middle of LOAD
    load_ramp_identity();
    k_len = KWB'(4);
    start = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < NN; i++) begin
      a_col[W*i +: W] = W'(7);
      b_row[W*i +: W] = W'(9);
    end
    tick();
    tick();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    tick();
    check("midrst in_ready", 64'(in_ready), 64'd0);
    check("midrst c_valid", 64'(c_valid), 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    check("midrst c_flat", 64'(|c_flat), 64'd0);
    rst_n = 1'b1;
    bad   = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (c_valid || done || busy) bad = 1'b1;
    end
    check("midrst quiet", 64'(bad), 64'd0);
    full_run("after rst", 4, 1'b0, 0);

    // Zero-length and over-long runs
    full_run("k0", 0, 1'b0, 0);
    check("k0 zero", 64'(|c_flat), 64'd0);
    load_random();
    full_run("k20", 20, 1'b1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/systolic_nxn_stream_mult.md
SYSTOLIC_NXN_STREAM_MULT -- requirements
Module: systolic_nxn_stream_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits.
REQ-002 SHALL have parameter N, default 4, array dimension (N x N PEs, N >= 2).
REQ-003 SHALL have parameter KMAX, default 16, maximum inner dimension per run.
REQ-004 SHALL have derived constants ACC_W = 2*WIDTH + clog2(KMAX) and KW = clog2(KMAX+1).
REQ-005 SHALL have ports: clk  in  1  single clock, rising edge; rst_n  in  1  synchronous active-low reset.
REQ-006 SHALL have ports: start  in  1  begin run; k_len  in  KW  inner dimension, sampled on accepted start.
REQ-007 SHALL have ports: in_valid  in  1; in_ready  out  1; a_col  in  WIDTH*N  column k of A, element i at [WIDTH*i +: WIDTH]; b_row  in  WIDTH*N  row k of B, element j at [WIDTH*j +: WIDTH].
REQ-008 SHALL have ports: c_flat  out  ACC_W*N*N  result, C[i][j] at [ACC_W*(N*i+j) +: ACC_W]; c_valid  out  1; c_ready  in  1; busy  out  1; done  out  1  one-cycle pulse on result handshake.

Function
REQ-009 SHALL implement FSM IDLE -> LOAD -> FLUSH -> OUT -> IDLE.
REQ-010 IDLE: start=1 accepted; clears all accumulators; latches k_len (values > KMAX saturate to KMAX); k_len=0 goes directly to OUT with C all zero.
REQ-011 LOAD: in_ready=1; each in_valid&&in_ready edge consumes one (a_col, b_row) pair; after k_len pairs -> FLUSH.
REQ-012 Input skew: A element i delayed i cycles into row i, B element j delayed j cycles into column j; bubble cycles (in_valid=0) inject zero pairs so alignment is preserved.
REQ-013 Each PE(i,j) SHALL multiply-accumulate its aligned pair, forward A right and B down with one register stage each.
REQ-014 FLUSH SHALL last 2N-1 cycles; c_valid SHALL rise on the 2N-th rising edge after the edge accepting the last pair.
REQ-015 OUT: c_valid=1, c_flat stable until c_valid&&c_ready; that edge pulses done for one cycle and returns to IDLE.
REQ-016 busy=1 in every state except IDLE; start outside IDLE SHALL be ignored.
REQ-017 in_ready SHALL be 0 in IDLE, FLUSH and OUT.
REQ-018 Products SHALL be full 2*WIDTH, extended to ACC_W before accumulation; no overflow possible for k_len <= KMAX.
REQ-019 c_flat SHALL retain last result after OUT until next accepted start clears it.

Reset
REQ-020 rst_n=0 at a rising edge SHALL force IDLE, zero accumulators, skew registers and pipeline, regardless of state.
REQ-021 Reset values: in_ready=0, c_valid=0, busy=0, done=0, c_flat=0.
REQ-022 Reset mid-LOAD or mid-FLUSH SHALL discard the partial run; no c_valid or done follows.

Configuration
REQ-023 Macro SYSTOLIC_SIGNED_EN defined: operands two's complement, products and accumulators sign-extended to ACC_W.
REQ-024 SYSTOLIC_SIGNED_EN undefined: operands unsigned, zero-extended.

Structure
REQ-025 Package systolic_pkg SHALL hold the FSM state enum and the ACC_W/KW width helper functions.
REQ-026 Sub-module systolic_pe SHALL implement one PE (MAC plus A/B forwarding registers), instantiated N*N times via generate.

Verification (N=4, WIDTH=16, KMAX=16)
REQ-027 A[i][j]=i+j, B=identity, k_len=4, in_valid held 1 -> C=A, c_valid on 8th edge after last accept.
REQ-028 Same data, in_valid toggled every other cycle -> identical C; in_ready low after 4th accept.
REQ-029 A all 0xFFFF, B all 2, k_len=16 -> C all -32 with SYSTOLIC_SIGNED_EN, all 2097120 without.
REQ-030 c_ready held 0 for 5 cycles in OUT, start pulsed -> c_flat stable, start ignored, done pulses once on c_ready=1.
REQ-031 rst_n=0 after 2 accepted pairs -> next edge all outputs zero, IDLE; following run of REQ-027 correct.
REQ-032 start with k_len=0 -> c_valid next edge, C all zero; k_len=20 -> exactly 16 pairs accepted.
